packet_sort_mode: RTL and testbench
===================================

// Module: packet_sort_mode
// PURPOSE
//  Stream-packet sorter, next generation of the single-mode sorter: buffers one packet of
//  up to MAX_PKT_LEN words, sorts it ascending or descending (direction chosen per packet)
//  and replays it as a packet of the same length. Sits between two Avalon-ST
//  (data/sop/eop/valid/ready) links in the packet datapath.
//  Adds over the previous sorter: run-time direction, overlong-packet truncation with error
//  pulse, and defined recovery from malformed framing.
// PARAMETERS
//  DWIDTH       8   word width, bits; unsigned compare
//  MAX_PKT_LEN  16  max words per packet, >=2; storage depth
// PORTS
//  clk_i                1 in   clock, all logic on rising edge
//  srst_n_i             1 in   synchronous reset, active-low
//  snk_data_i           DWIDTH in   input word
//  snk_startofpacket_i  1 in   first word of packet
//  snk_endofpacket_i    1 in   last word of packet
//  snk_valid_i          1 in   input word valid
//  snk_ready_o          1 out  block accepts a word this cycle
//  snk_descend_i        1 in   sort direction, sampled with SOP word (1 = descending)
//  src_data_o           DWIDTH out  output word
//  src_startofpacket_o  1 out  first output word
//  src_endofpacket_o    1 out  last output word
//  src_valid_o          1 out  output word valid
//  src_ready_i          1 in   downstream accepts word
//  err_overflow_o       1 out  1-cycle pulse: packet exceeded MAX_PKT_LEN, truncated
// BEHAVIOUR
//  - Reset (srst_n_i=0 at edge): FSM->IDLE, length cnt=0, all src_* outputs 0,
//    err_overflow_o=0, snk_ready_o=1 from the first cycle after reset. Reset mid-packet or
//    mid-output aborts at once; no further output words for that packet.
//  - Handshake: word transfers when valid && ready on the same edge. While src_valid_o=1 with
//    src_ready_i=0, src_data/sop/eop are held stable.
//  - FSM states:
//    - IDLE: snk_ready_o=1. Words with valid but no SOP are dropped. SOP word: store at
//      index 0, latch snk_descend_i, cnt=1. SOP+EOP together: go to SORT with cnt=1.
//      SOP alone: go to RECV.
//    - RECV: snk_ready_o=1.
//      - Word with cnt<MAX_PKT_LEN: stored at index cnt, cnt++.
//      - Word with cnt==MAX_PKT_LEN: discarded; an error flag is set.
//      - Word carrying EOP: go to SORT. err_overflow_o pulses in the cycle after EOP if the
//        flag is set.
//      - New SOP inside RECV: the current packet is abandoned. Restart at index 0, relatch
//        the direction, cnt=1.
//    - SORT: snk_ready_o=0. Odd-even transposition, exactly MAX_PKT_LEN cycles. Pass k
//      compares pairs (i,i+1) with i%2==k%2 and i+1<cnt, and swaps if out of order for the
//      latched direction. Equal values are never swapped. Then go to SEND.
//    - SEND: snk_ready_o=0. src_valid_o=1, emitting indices 0..cnt-1 in order.
//      src_startofpacket_o=1 on index 0; src_endofpacket_o=1 on index cnt-1 (both on cnt=1).
//      After the EOP transfer: go to IDLE, src_valid_o=0 next cycle.
//  - Latency: EOP accepted at edge T -> first src_valid_o=1 in the cycle after edge
//    T+MAX_PKT_LEN+1, independent of packet length. With src_ready_i=1 the output is one word
//    per cycle.
//  - Back-to-back: a new packet is accepted only after the previous output EOP has
//    transferred.
//  - Words stored in registers; the sort uses MAX_PKT_LEN/2 comparators in parallel.
// TESTING
//  1. Reset; send 2 words {0x05,0x03}, descend=0, src_ready=1 -> output {0x03,0x05},
//     sop on first, eop on second, first valid at EOP+MAX_PKT_LEN+1.
//  2. 10 words, snk_valid 50% random, descend=1 -> output is the same multiset in
//     non-increasing order; src_valid_o and snk_ready_o are never 1 together.
//  3. 20-word packet with MAX_PKT_LEN=16 -> err_overflow_o 1-cycle pulse; 16 sorted words
//     out from the first 16 inputs.
//  4. Single-word packet (SOP+EOP, 0xAA) -> one output word 0xAA with sop=eop=1.
//  5. src_ready_i toggled randomly during SEND -> data stable while stalled, no loss or
//     duplication; words without SOP in IDLE are dropped.
//  6. Reset asserted mid-RECV and mid-SEND -> src_valid_o=0 after that edge; a following
//     clean 4-word packet is sorted correctly.

Source files
------------

// File: rtl/packet_sort_mode.sv
// Packet sorter: buffers one Avalon-ST packet and sorts it
// with odd-even transposition. Direction is chosen per packet.
module packet_sort_mode #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              snk_descend_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              err_overflow_o
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam int IW = $clog2(MAX_PKT_LEN);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    SORT,
    SEND
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DWIDTH-1:0] mem [MAX_PKT_LEN];
  logic [DWIDTH-1:0] srt [MAX_PKT_LEN];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     oidx;
  logic [IW-1:0]     pass;
  logic              desc;
  logic              ovf;
  logic              acc;
  logic              last_pass;
  logic              out_done;
  logic              out_load;

  assign acc       = snk_valid_i && snk_ready_o;
  assign last_pass = (state == SORT) &&
                     (pass == IW'(MAX_PKT_LEN - 1));
  assign out_done  = src_valid_o && src_ready_i &&
                     src_endofpacket_o;
  assign out_load  = (state == SEND) && !out_done &&
                     (!src_valid_o || src_ready_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next state and sink-side ready
  always_comb begin
    state_nxt   = state;
    snk_ready_o = 1'b0;
    case (state)
      IDLE: begin
        snk_ready_o = 1'b1;
        if (snk_valid_i && snk_startofpacket_i)
          state_nxt = snk_endofpacket_i ? SORT : RECV;
      end
      RECV: begin
        snk_ready_o = 1'b1;
        if (snk_valid_i && snk_endofpacket_i)
          state_nxt = SORT;
      end
      SORT: begin
        if (last_pass) state_nxt = SEND;
      end
      SEND: begin
        if (out_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One transposition pass: disjoint pairs of matching parity
  always_comb begin
    srt = mem;
    for (int i = 0; i < MAX_PKT_LEN - 1; i++) begin
      if ((i % 2) == int'(pass[0]) &&
          (i + 1) < int'(cnt)) begin
        if (desc ? (mem[i] < mem[i+1])
                 : (mem[i] > mem[i+1])) begin
          srt[i]   = mem[i+1];
          srt[i+1] = mem[i];
        end
      end
    end
  end

  // Capture, sort passes and output register
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      cnt                 <= '0;
      oidx                <= '0;
      pass                <= '0;
      desc                <= 1'b0;
      ovf                 <= 1'b0;
      err_overflow_o      <= 1'b0;
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_valid_o         <= 1'b0;
    end else begin
      err_overflow_o <= 1'b0;
      if (acc && snk_startofpacket_i) begin
        mem[0] <= snk_data_i;
        desc   <= snk_descend_i;
        cnt    <= CW'(1);
        ovf    <= 1'b0;
      end else if (acc && state == RECV) begin
        if (cnt < CW'(MAX_PKT_LEN)) begin
          mem[cnt[IW-1:0]] <= snk_data_i;
          cnt              <= cnt + CW'(1);
        end else begin
          ovf <= 1'b1;
        end
        if (snk_endofpacket_i)
          err_overflow_o <= ovf ||
                            (cnt == CW'(MAX_PKT_LEN));
      end
      if (state == SORT) begin
        mem  <= srt;
        pass <= pass + IW'(1);
      end else begin
        pass <= '0;
      end
      if (last_pass) oidx <= '0;
      if (out_done) begin
        src_valid_o         <= 1'b0;
        src_startofpacket_o <= 1'b0;
        src_endofpacket_o   <= 1'b0;
        src_data_o          <= '0;
      end else if (out_load) begin
        src_valid_o         <= 1'b1;
        src_data_o          <= mem[oidx[IW-1:0]];
        src_startofpacket_o <= (oidx == '0);
        src_endofpacket_o   <= (oidx == cnt - CW'(1));
        oidx                <= oidx + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_packet_sort_mode.sv
// Bench for packet_sort_mode: random packets checked
// against a queue-sort reference model.
module tb_packet_sort_mode;

  localparam int DW = 8;
  localparam int ML = 16;

  logic          clk = 1'b0;
  logic          srst_n_i;
  logic [DW-1:0] snk_data_i;
  logic          snk_startofpacket_i;
  logic          snk_endofpacket_i;
  logic          snk_valid_i;
  logic          snk_ready_o;
  logic          snk_descend_i;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          src_valid_o;
  logic          src_ready_i;
  logic          err_overflow_o;

  always #5 clk = ~clk;

  packet_sort_mode #(.DWIDTH(DW), .MAX_PKT_LEN(ML)) dut (
    .clk_i               (clk),
    .srst_n_i            (srst_n_i),
    .snk_data_i          (snk_data_i),
    .snk_startofpacket_i (snk_startofpacket_i),
    .snk_endofpacket_i   (snk_endofpacket_i),
    .snk_valid_i         (snk_valid_i),
    .snk_ready_o         (snk_ready_o),
    .snk_descend_i       (snk_descend_i),
    .src_data_o          (src_data_o),
    .src_startofpacket_o (src_startofpacket_o),
    .src_endofpacket_o   (src_endofpacket_o),
    .src_valid_o         (src_valid_o),
    .src_ready_i         (src_ready_i),
    .err_overflow_o      (err_overflow_o)
  );

  int checks = 0;
  int errors = 0;

  int  exp_w[$];
  int  exp_n[$];
  time exp_t[$];
  time last_eop_t = 0;
  int  gotq[$];
  int  err_seen = 0;
  int  exp_err = 0;
  int  rdy_mode = 0;
  bit  seen_first = 0;
  bit  mon_en = 0;
  bit  hold_v = 0;
  bit  prev_err = 0;
  logic [DW-1:0] hold_d;
  logic hold_s, hold_e;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Downstream ready pattern, changed just after each edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       src_ready_i = 1'b1;
      1:       src_ready_i = 1'($urandom_range(1));
      default: src_ready_i = 1'b0;
    endcase
  end

  task automatic put_word(input int d, input bit sop,
                          input bit eop, input bit desc,
                          input int gap, output time t);
    int g = 0;
    @(negedge clk);
    while (32'($urandom_range(99)) < 32'(gap)) begin
      snk_valid_i = 1'b0;
      @(negedge clk);
    end
    snk_data_i          = DW'(d);
    snk_startofpacket_i = sop;
    snk_endofpacket_i   = eop;
    snk_descend_i       = desc;
    snk_valid_i         = 1'b1;
    while (!snk_ready_o && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk("snk_ready_wait", 0, 1);
    @(posedge clk);
    t = $time;
    if (eop) last_eop_t = t;
  endtask

  task automatic send_words(input int w[$], input bit desc,
                            input int gap);
    int  m[$];
    time t;
    for (int i = 0; i < w.size(); i++)
      put_word(w[i], i == 0, i == w.size() - 1,
               desc, gap, t);
    @(negedge clk);
    snk_valid_i = 1'b0;
    for (int i = 0; i < w.size() && i < ML; i++)
      m.push_back(w[i]);
    m.sort();
    if (desc) m.reverse();
    foreach (m[i]) exp_w.push_back(m[i]);
    exp_n.push_back(m.size());
    exp_t.push_back(t);
    if (w.size() > ML) exp_err++;
  endtask

  task automatic send_rand(input int n, input bit desc,
                           input int gap);
    int w[$];
    for (int i = 0; i < n; i++)
      w.push_back(int'($urandom_range(255)));
    send_words(w, desc, gap);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_n.size() > 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (exp_n.size() > 0)
      chk("drain_timeout", 32'(exp_n.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic flush_expected();
    int n;
    if (exp_n.size() > 0) begin
      n = exp_n.pop_front();
      repeat (n) void'(exp_w.pop_front());
      void'(exp_t.pop_front());
    end
    gotq.delete();
    seen_first = 0;
    hold_v     = 0;
  endtask

  // Output monitor and protocol checks
  always @(negedge clk) begin
    int n;
    int e;
    if (mon_en) begin
      if (src_valid_o && snk_ready_o)
        chk("valid_ready_excl", 1, 0);
      if (hold_v) begin
        chk("stall_valid", 32'(src_valid_o), 1);
        chk("stall_data", 32'(src_data_o), 32'(hold_d));
        chk("stall_sop", 32'(src_startofpacket_o),
            32'(hold_s));
        chk("stall_eop", 32'(src_endofpacket_o),
            32'(hold_e));
      end
      hold_v = src_valid_o && !src_ready_i;
      hold_d = src_data_o;
      hold_s = src_startofpacket_o;
      hold_e = src_endofpacket_o;
      if (err_overflow_o) begin
        err_seen++;
        chk("err_width", 32'(prev_err), 0);
        chk("err_time", 32'($time - last_eop_t), 5);
      end
      prev_err = err_overflow_o;
      if (src_valid_o && !seen_first) begin
        seen_first = 1;
        if (exp_t.size() == 0)
          chk("unexpected_out", 1, 0);
        else
          chk("latency", 32'($time - exp_t[0]),
              32'((ML + 1) * 10 + 5));
      end
      if (src_valid_o && src_ready_i) begin
        chk("sop_pos", 32'(src_startofpacket_o),
            32'(gotq.size() == 0));
        gotq.push_back(int'(src_data_o));
        if (src_endofpacket_o) begin
          if (exp_n.size() == 0) begin
            chk("unexpected_pkt", 1, 0);
          end else begin
            n = exp_n.pop_front();
            void'(exp_t.pop_front());
            chk("pkt_len", 32'(gotq.size()), 32'(n));
            for (int i = 0; i < n; i++) begin
              e = exp_w.pop_front();
              chk("word",
                  i < gotq.size() ? 32'(gotq[i]) : '1,
                  32'(e));
            end
          end
          gotq.delete();
          seen_first = 0;
        end else if (gotq.size() > ML) begin
          chk("missing_eop", 32'(gotq.size()), ML);
          gotq.delete();
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    time t;
    int  e0;
    int  g;
    srst_n_i            = 1'b0;
    snk_data_i          = '0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i   = 1'b0;
    snk_valid_i         = 1'b0;
    snk_descend_i       = 1'b0;
    src_ready_i         = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(src_valid_o), 0);
    chk("rst_sop", 32'(src_startofpacket_o), 0);
    chk("rst_eop", 32'(src_endofpacket_o), 0);
    chk("rst_data", 32'(src_data_o), 0);
    chk("rst_err", 32'(err_overflow_o), 0);
    srst_n_i = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(snk_ready_o), 1);
    mon_en = 1;

    // Two words ascending
    rdy_mode = 0;
    send_words('{8'h05, 8'h03}, 1'b0, 0);
    wait_drain();

    // Ten words descending with gappy input
    rdy_mode = 1;
    send_rand(10, 1'b1, 50);
    wait_drain();

    // Overlong packet is truncated and flagged
    e0 = err_seen;
    send_rand(20, 1'b0, 20);
    wait_drain();
    chk("ovf_pulse_count", 32'(err_seen - e0), 1);

    // Single-word packet
    e0 = err_seen;
    send_words('{8'hAA}, 1'($urandom_range(1)), 0);
    wait_drain();
    chk("no_ovf_single", 32'(err_seen - e0), 0);

    // Stray words in IDLE, then random packets
    put_word(8'h77, 1'b0, 1'b0, 1'b0, 0, t);
    put_word(8'h01, 1'b0, 1'b1, 1'b0, 0, t);
    @(negedge clk);
    snk_valid_i = 1'b0;
    send_rand(8, 1'b0, 30);
    wait_drain();
    for (int p = 0; p < 6; p++) begin
      send_rand(int'($urandom_range(1, ML + 4)),
                1'($urandom_range(1)), 30);
      wait_drain();
    end
    send_rand(ML, 1'b1, 0);
    wait_drain();

    // Reset in the middle of reception
    rdy_mode = 0;
    put_word(8'h10, 1'b1, 1'b0, 1'b0, 0, t);
    put_word(8'h20, 1'b0, 1'b0, 1'b0, 0, t);
    put_word(8'h30, 1'b0, 1'b0, 1'b0, 0, t);
    @(negedge clk);
    snk_valid_i = 1'b0;
    srst_n_i    = 1'b0;
    @(negedge clk);
    srst_n_i = 1'b1;
    chk("recv_rst_valid", 32'(src_valid_o), 0);
    chk("recv_rst_ready", 32'(snk_ready_o), 1);
    repeat (ML + 4) @(negedge clk);
    chk("recv_rst_quiet", 32'(src_valid_o), 0);
    send_words('{8'h09, 8'h02, 8'h07, 8'h04}, 1'b0, 0);
    wait_drain();

    // Reset while a packet is being sent
    rdy_mode = 2;
    send_rand(5, 1'b1, 0);
    g = 0;
    while (!src_valid_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!src_valid_o) chk("send_wait", 0, 1);
    mon_en   = 0;
    srst_n_i = 1'b0;
    @(negedge clk);
    srst_n_i = 1'b1;
    chk("send_rst_valid", 32'(src_valid_o), 0);
    chk("send_rst_sop", 32'(src_startofpacket_o), 0);
    rdy_mode = 0;
    flush_expected();
    mon_en = 1;
    repeat (ML + 4) @(negedge clk);
    chk("send_rst_quiet", 32'(src_valid_o), 0);
    send_words('{8'h40, 8'hC0, 8'h00, 8'hFF}, 1'b1, 0);
    wait_drain();

    chk("err_total", 32'(err_seen), 32'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
